uart_rx_os: RTL and testbench

- UART serial receiver: recovers 8N1-style frames from asynchronous line `rx` using a 16x oversampling tick from the shared baud tick generator.
- Sits at the receive end of the UART link, opposite the transmitter. Delivers one parallel byte per frame with a one-cycle strobe and a framing-error flag.
- Integration: the tick source divisor is set to f_clk / (16 x baud).

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx_os.sv | 129 ++++++++++++
 tb/tb_uart_rx_os.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } rx_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_START   = 7;
  localparam int unsigned DEF_DBIT    = 8;
  localparam int unsigned DEF_SB_TICK = 16;

  localparam int unsigned S_W = 5;
  localparam int unsigned N_W = 3;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver: recovers LSB-first frames from rx using a 16x oversampling tick.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DEF_DBIT,
  parameter int unsigned SB_TICK = DEF_SB_TICK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  rx_state_e state_q, state_d;

  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            rx_s;

  logic start_mid, data_end, last_bit, stop_end;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    start_mid = s_tick && (s_q == S_W'(MID_START));
    data_end  = s_tick && (s_q == S_W'(OVERSAMPLE - 1));
    last_bit  = (n_q == N_W'(DBIT - 1));
    stop_end  = s_tick && (s_q == S_W'(SB_TICK - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (start_mid) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (data_end && last_bit) state_d = ST_STOP;
      ST_STOP:  if (stop_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; a false start leaves dout and frame_err untouched.
  always_comb begin
    s_d    = s_q;
    n_d    = n_q;
    b_d    = b_q;
    dout_d = dout_q;
    ferr_d = ferr_q;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) s_d = '0;
      end
      ST_START: begin
        if (start_mid) begin
          s_d = '0;
          n_d = '0;
        end else if (s_tick) begin
          s_d = s_q + S_W'(1);
        end
      end
      ST_DATA: begin
        if (data_end) begin
          s_d = '0;
          b_d = {rx_s, b_q[DBIT-1:1]};
          if (!last_bit) n_d = n_q + N_W'(1);
        end else if (s_tick) begin
          s_d = s_q + S_W'(1);
        end
      end
      ST_STOP: begin
        if (stop_end) begin
          dout_d = b_q;
          ferr_d = ~rx_s;
          done_d = 1'b1;
        end else if (s_tick) begin
          s_d = s_q + S_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= '0;
      n_q    <= '0;
      b_q    <= '0;
      dout_q <= '0;
      ferr_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      n_q    <= n_d;
      b_q    <= b_d;
      dout_q <= dout_d;
      ferr_q <= ferr_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: framed bytes on rx with s_tick every 4 clk (64 clk per bit).
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  localparam int BIT_CLK = 64;

  typedef struct {
    logic [7:0] data;
    logic       stop_val;
    int         stop_len;
    int         gap_bits;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    int         dt;
  } rec_t;

  rec_t rec_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stop_cyc = 0;
  logic [1:0] tdiv = 2'd0;

  uart_rx_os dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    tdiv   = tdiv + 2'd1;
    s_tick = (tdiv == 2'd0);
  end

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) rec_q.push_back('{dout, frame_err, cyc - stop_cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int len);
    rx = v;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int stop_len,
                            input int gap_bits);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLK);
    stop_cyc = cyc;
    drive_bit(stop_val, stop_len);
    if (gap_bits > 0) drive_bit(1'b1, BIT_CLK * gap_bits);
    rx = 1'b1;
  endtask

  task automatic chk_rec(input string nm, input logic [7:0] ed, input logic ef, input bit chk_dt);
    rec_t r;
    chk({nm, "_cnt"}, 32'(rec_q.size() > 0), 32'd1);
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      chk({nm, "_dout"}, 32'(r.d), 32'(ed));
      chk({nm, "_ferr"}, 32'(r.fe), 32'(ef));
      if (chk_dt) chk({nm, "_strobe_pos"}, 32'(r.dt >= 32 && r.dt <= 35), 32'd1);
    end
  endtask

  vec_t vecs[5];

  initial begin
    bit seen;
    vecs[0] = '{8'hA5, 1'b1, 64, 2, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 64, 0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 64, 2, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 40, 3, 8'h3C, 1'b1};
    vecs[4] = '{8'h11, 1'b1, 64, 2, 8'h11, 1'b0};

    // Reset held with the line low and ticks running.
    #2 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_done", 32'(rx_done_tick), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rel_busy", 32'(busy), (k == 3) ? 32'd1 : 32'd0);
    end

    // Line stays low: a break frame is reported as zero data with a framing error.
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) seen = 1'b1;
    end
    rx = 1'b1;
    chk("break_strobe_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    chk_rec("break", 8'h00, 1'b1, 1'b0);
    drive_bit(1'b1, BIT_CLK * 3);
    chk("break_no_extra", 32'(rec_q.size()), 32'd0);
    chk("break_idle", 32'(busy), 32'd0);

    // Table of frames, including back-to-back 00/FF and a framing error.
    for (int i = 0; i < 5; i++)
      send_frame(vecs[i].data, vecs[i].stop_val, vecs[i].stop_len, vecs[i].gap_bits);
    chk("tbl_count", 32'(rec_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_rec($sformatf("tbl%0d", i), vecs[i].exp_dout, vecs[i].exp_ferr, 1'b1);

    // Glitch shorter than half a bit: false start, no strobe, dout kept.
    drive_bit(1'b0, 8);
    chk("glitch_busy", 32'(busy), 32'd1);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, BIT_CLK * 2);
    chk("glitch_no_strobe", 32'(rec_q.size()), 32'd0);
    chk("glitch_dout", 32'(dout), 32'h11);
    chk("glitch_ferr", 32'(frame_err), 32'd0);
    chk("glitch_idle", 32'(busy), 32'd0);

    // Reset asserted in the middle of data bit 4 of 8'hC3.
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i), BIT_CLK);
    drive_bit(1'b0, 32);
    chk("mid_busy_before", 32'(busy), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_done", 32'(rx_done_tick), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    drive_bit(1'b1, BIT_CLK * 2);
    chk("mid_no_strobe", 32'(rec_q.size()), 32'd0);
    send_frame(8'h5A, 1'b1, 64, 2);
    chk("post_rst_count", 32'(rec_q.size()), 32'd1);
    chk_rec("post_rst", 8'h5A, 1'b0, 1'b1);
    chk("post_rst_dout_held", 32'(dout), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
